// File: rtl/output_ram_writer_pkg.sv
// Shared image defaults, writer state type and address-width helper for the frame-buffer write side.
package output_ram_writer_pkg;

    localparam int unsigned IMG_WIDTH   = 128;
    localparam int unsigned IMG_HEIGHT  = 128;
    localparam int unsigned PIX_W       = 8;
    localparam int unsigned IMG_COORD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } writerState_e;

    // Bits needed to address a RAM of the given depth (at least one).
    function automatic int unsigned addrWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/output_frame_ram.sv
// Simple dual-port frame RAM: synchronous write, registered read-first read; a disabled read returns zero.
module output_frame_ram #(
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Non-blocking read of mem gives the pre-write contents on a same-address collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end else begin
            rdData <= '0;
        end
    end

endmodule

// File: rtl/output_ram_writer.sv
// Raster-scan frame writer with a col/row read port.
// Define CONTINUOUS_FRAME_EN to capture frames back-to-back after a single iStart.
module output_ram_writer
    import output_ram_writer_pkg::*;
#(
    parameter int unsigned WIDTH   = IMG_WIDTH,
    parameter int unsigned HEIGHT  = IMG_HEIGHT,
    parameter int unsigned DATA_W  = PIX_W,
    parameter int unsigned COORD_W = IMG_COORD_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iStart,
    input  logic               iValid,
    input  logic [DATA_W-1:0]  iData,
    output logic               oReady,
    output logic [COORD_W-1:0] oWrCol,
    output logic [COORD_W-1:0] oWrRow,
    output logic               oBusy,
    output logic               oDone,
    input  logic [COORD_W-1:0] iRdCol,
    input  logic [COORD_W-1:0] iRdRow,
    output logic [DATA_W-1:0]  oRdData
);

    localparam int unsigned DEPTH  = WIDTH * HEIGHT;
    localparam int unsigned ADDR_W = addrWidth(DEPTH);

    writerState_e      state;
    logic              transfer;
    logic              colLast;
    logic              rowLast;
    logic              lastPixel;
    logic              ramWrEn;
    logic              rdInRange;
    logic [ADDR_W-1:0] wrAddr;
    logic [ADDR_W-1:0] rdAddr;

    assign transfer  = iValid & oReady;
    assign colLast   = (oWrCol == COORD_W'(WIDTH - 1));
    assign rowLast   = (oWrRow == COORD_W'(HEIGHT - 1));
    assign lastPixel = colLast & rowLast;
    assign ramWrEn   = transfer & ~reset;

    // Linear addresses: row*WIDTH + col at RAM address width.
    assign wrAddr = ADDR_W'(oWrRow) * ADDR_W'(WIDTH) + ADDR_W'(oWrCol);
    assign rdAddr = ADDR_W'(iRdRow) * ADDR_W'(WIDTH) + ADDR_W'(iRdCol);

    assign rdInRange = (32'(iRdCol) < WIDTH) && (32'(iRdRow) < HEIGHT);

    // Capture FSM with the write counters and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            oReady <= 1'b0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
            oWrCol <= '0;
            oWrRow <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state  <= WRITE;
                        oReady <= 1'b1;
                        oBusy  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (transfer) begin
                        if (lastPixel) begin
                            oWrCol <= '0;
                            oWrRow <= '0;
                            oDone  <= 1'b1;
`ifndef CONTINUOUS_FRAME_EN
                            state  <= IDLE;
                            oReady <= 1'b0;
                            oBusy  <= 1'b0;
`endif
                        end else if (colLast) begin
                            oWrCol <= '0;
                            oWrRow <= oWrRow + COORD_W'(1);
                        end else begin
                            oWrCol <= oWrCol + COORD_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    oReady <= 1'b0;
                    oBusy  <= 1'b0;
                end
            endcase
        end
    end

    output_frame_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) uFrameRam (
        .clock  (clock),
        .reset  (reset),
        .wrEn   (ramWrEn),
        .wrAddr (wrAddr),
        .wrData (iData),
        .rdEn   (rdInRange),
        .rdAddr (rdAddr),
        .rdData (oRdData)
    );

endmodule

// File: tb/tb_output_ram_writer.sv
// Scoreboard bench for output_ram_writer: read expectations queued at drive time, checked one edge later.
module tb_output_ram_writer;

    localparam int unsigned W    = 128;
    localparam int unsigned H    = 128;
    localparam int unsigned CW   = 8;
    localparam int unsigned NPIX = W * H;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          iStart = 1'b0;
    logic          iValid = 1'b0;
    logic [7:0]    iData = 8'h00;
    logic          oReady;
    logic [CW-1:0] oWrCol;
    logic [CW-1:0] oWrRow;
    logic          oBusy;
    logic          oDone;
    logic [CW-1:0] iRdCol = '0;
    logic [CW-1:0] iRdRow = '0;
    logic [7:0]    oRdData;

    always #5 clock = ~clock;

    output_ram_writer dut (
        .clock   (clock),
        .reset   (reset),
        .iStart  (iStart),
        .iValid  (iValid),
        .iData   (iData),
        .oReady  (oReady),
        .oWrCol  (oWrCol),
        .oWrRow  (oWrRow),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .iRdCol  (iRdCol),
        .iRdRow  (iRdRow),
        .oRdData (oRdData)
    );

    typedef struct {
        logic [7:0] data;
        bit         check;
    } rdExp_t;

    rdExp_t     rdQ[$];
    logic [7:0] model [NPIX];
    bit         known [NPIX];
    bit         expState = 1'b0;
    int         expCol = 0;
    int         expRow = 0;
    bit         expDone = 1'b0;
    int         nAssert = 0;
    int         nFail = 0;
    int         cycle = 0;
    int         doneAt[$];

    // Drive one cycle, queue the read expectation, advance the reference model, sample after the edge.
    task automatic stepCycle(input bit rst, input bit start, input bit valid, input logic [7:0] data,
                             input int rdCol, input int rdRow);
        rdExp_t e;
        bit     xfer;
        @(negedge clock);
        reset  = rst;
        iStart = start;
        iValid = valid;
        iData  = data;
        iRdCol = CW'(rdCol);
        iRdRow = CW'(rdRow);
        if (rst || rdCol >= int'(W) || rdRow >= int'(H)) begin
            e.data  = 8'h00;
            e.check = 1'b1;
        end else begin
            e.data  = model[rdRow * W + rdCol];
            e.check = known[rdRow * W + rdCol];
        end
        rdQ.push_back(e);
        xfer = !rst && valid && expState;
        if (xfer) begin
            model[expRow * W + expCol] = data;
            known[expRow * W + expCol] = 1'b1;
        end
        expDone = 1'b0;
        if (rst) begin
            expState = 1'b0;
            expCol   = 0;
            expRow   = 0;
        end else if (!expState) begin
            if (start) expState = 1'b1;
        end else if (xfer) begin
            if (expCol == int'(W) - 1 && expRow == int'(H) - 1) begin
                expCol  = 0;
                expRow  = 0;
                expDone = 1'b1;
`ifndef CONTINUOUS_FRAME_EN
                expState = 1'b0;
`endif
            end else if (expCol == int'(W) - 1) begin
                expCol = 0;
                expRow = expRow + 1;
            end else begin
                expCol = expCol + 1;
            end
        end
        @(posedge clock);
        #1;
        cycle = cycle + 1;
        if (oDone === 1'b1) doneAt.push_back(cycle);
    endtask

    task automatic test_reset();
        rdExp_t e;
        stepCycle(1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
        e = rdQ.pop_front();
        stepCycle(1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
        e = rdQ.pop_front();
        nAssert += 6;
        if (oReady !== 1'b0) begin nFail++; $display("FAIL reset_oReady got=%b exp=0", oReady); end
        if (oBusy !== 1'b0) begin nFail++; $display("FAIL reset_oBusy got=%b exp=0", oBusy); end
        if (oDone !== 1'b0) begin nFail++; $display("FAIL reset_oDone got=%b exp=0", oDone); end
        if (oWrCol !== '0) begin nFail++; $display("FAIL reset_oWrCol got=%0d exp=0", oWrCol); end
        if (oWrRow !== '0) begin nFail++; $display("FAIL reset_oWrRow got=%0d exp=0", oWrRow); end
        if (oRdData !== e.data) begin nFail++; $display("FAIL reset_oRdData got=%h exp=%h", oRdData, e.data); end
        doneAt.delete();
    endtask

    // Stream a frame (optionally with 1-0-1 iValid gaps), reading back the last written pixel each cycle.
    task automatic test_frame(input string name, input bit gaps, input bit flat, input logic [7:0] flatVal);
        rdExp_t     e;
        int         written = 0;
        int         lastCol = 0;
        int         lastRow = 0;
        bit         v;
        logic [7:0] d;
        doneAt.delete();
        stepCycle(1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
        e = rdQ.pop_front();
        nAssert++;
        if (oReady !== 1'b1) begin nFail++; $display("FAIL %s_start_oReady got=%b exp=1", name, oReady); end
        for (int c = 0; written < int'(NPIX) && c < 3 * int'(NPIX); c++) begin
            v = gaps ? (c % 2 == 0) : 1'b1;
            d = flat ? flatVal : 8'(expCol + expRow);
            if (v) begin
                stepCycle(1'b0, 1'b0, 1'b1, d, lastCol, lastRow);
                lastCol = (written % int'(W));
                lastRow = (written / int'(W));
                written++;
            end else begin
                stepCycle(1'b0, 1'b0, 1'b0, d, lastCol, lastRow);
            end
            e = rdQ.pop_front();
            if (e.check) begin
                nAssert++;
                if (oRdData !== e.data) begin nFail++; $display("FAIL %s_rd c=%0d got=%h exp=%h", name, c, oRdData, e.data); end
            end
            nAssert += 4;
            if (oWrCol !== CW'(expCol) || oWrRow !== CW'(expRow)) begin
                nFail++; $display("FAIL %s_counters c=%0d got=(%0d,%0d) exp=(%0d,%0d)", name, c, oWrCol, oWrRow, expCol, expRow);
            end
            if (oDone !== expDone) begin nFail++; $display("FAIL %s_oDone c=%0d got=%b exp=%b", name, c, oDone, expDone); end
            if (oReady !== expState) begin nFail++; $display("FAIL %s_oReady c=%0d got=%b exp=%b", name, c, oReady, expState); end
            if (oBusy !== expState) begin nFail++; $display("FAIL %s_oBusy c=%0d got=%b exp=%b", name, c, oBusy, expState); end
        end
        stepCycle(1'b0, 1'b0, 1'b0, 8'h00, int'(W) - 1, int'(H) - 1);
        e = rdQ.pop_front();
        nAssert += 3;
        if (oRdData !== e.data) begin nFail++; $display("FAIL %s_rd_last got=%h exp=%h", name, oRdData, e.data); end
        if (oDone !== 1'b0) begin nFail++; $display("FAIL %s_oDone_after got=%b exp=0", name, oDone); end
        if (doneAt.size() != 1) begin nFail++; $display("FAIL %s_done_count got=%0d exp=1", name, doneAt.size()); end
    endtask

    task automatic test_full_frame();
        rdExp_t e;
        test_frame("full", 1'b0, 1'b0, 8'h00);
        stepCycle(1'b0, 1'b0, 1'b0, 8'h00, 5, 3);
        e = rdQ.pop_front();
        nAssert++;
        if (oRdData !== 8'h08) begin nFail++; $display("FAIL full_rd_5_3 got=%h exp=08", oRdData); end
    endtask

    task automatic test_idle_ignored();
        rdExp_t e;
        for (int i = 0; i < 4; i++) begin
            stepCycle(1'b0, 1'b0, 1'b1, 8'hAA, 0, 0);
            e = rdQ.pop_front();
            nAssert += 3;
            if (oReady !== 1'b0) begin nFail++; $display("FAIL idle_oReady got=%b exp=0", oReady); end
            if (oWrCol !== '0 || oWrRow !== '0) begin nFail++; $display("FAIL idle_counters got=(%0d,%0d) exp=(0,0)", oWrCol, oWrRow); end
            if (oRdData !== e.data) begin nFail++; $display("FAIL idle_rd00 got=%h exp=%h", oRdData, e.data); end
        end
        stepCycle(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
        e = rdQ.pop_front();
        nAssert++;
        if (oRdData !== 8'h00) begin nFail++; $display("FAIL idle_keep00 got=%h exp=00", oRdData); end
    endtask

    task automatic test_read_range();
        rdExp_t e;
        int     cols [3] = '{128, 3, 200};
        int     rows [3] = '{0, 128, 5};
        for (int i = 0; i < 3; i++) begin
            stepCycle(1'b0, 1'b0, 1'b0, 8'h00, cols[i], rows[i]);
            e = rdQ.pop_front();
            nAssert++;
            if (oRdData !== e.data) begin nFail++; $display("FAIL range_rd (%0d,%0d) got=%h exp=%h", cols[i], rows[i], oRdData, e.data); end
        end
    endtask

    task automatic test_reset_midframe();
        rdExp_t e;
        int     nDone;
        stepCycle(1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
        e = rdQ.pop_front();
        for (int i = 0; i < 200; i++) begin
            stepCycle(1'b0, 1'b0, 1'b1, 8'h11, 0, 0);
            e = rdQ.pop_front();
        end
        nAssert++;
        if (oWrCol !== CW'(72) || oWrRow !== CW'(1)) begin nFail++; $display("FAIL mid_counters got=(%0d,%0d) exp=(72,1)", oWrCol, oWrRow); end
        stepCycle(1'b1, 1'b0, 1'b1, 8'h22, 0, 0);
        e = rdQ.pop_front();
        nAssert += 2;
        if (oWrCol !== '0 || oWrRow !== '0) begin nFail++; $display("FAIL mid_rst_counters got=(%0d,%0d) exp=(0,0)", oWrCol, oWrRow); end
        if (oReady !== 1'b0) begin nFail++; $display("FAIL mid_rst_oReady got=%b exp=0", oReady); end
        test_frame("mid55", 1'b0, 1'b1, 8'h55);
        nDone = doneAt.size();
        nAssert++;
        if (nDone != 1) begin nFail++; $display("FAIL mid_done_pulses got=%0d exp=1", nDone); end
    endtask

    task automatic test_valid_gaps();
        test_frame("gaps", 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_same_addr();
        rdExp_t e;
        stepCycle(1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
        e = rdQ.pop_front();
        for (int i = 0; i < 300 && !(expCol == 10 && expRow == 2); i++) begin
            stepCycle(1'b0, 1'b0, 1'b1, 8'h00, 0, 0);
            e = rdQ.pop_front();
        end
        stepCycle(1'b0, 1'b0, 1'b1, 8'h3C, 10, 2);
        e = rdQ.pop_front();
        nAssert += 2;
        if (oRdData !== e.data) begin nFail++; $display("FAIL same_old_model got=%h exp=%h", oRdData, e.data); end
        if (oRdData !== 8'h0C) begin nFail++; $display("FAIL same_old got=%h exp=0c", oRdData); end
        stepCycle(1'b0, 1'b0, 1'b0, 8'h00, 10, 2);
        e = rdQ.pop_front();
        nAssert++;
        if (oRdData !== 8'h3C) begin nFail++; $display("FAIL same_new got=%h exp=3c", oRdData); end
        stepCycle(1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
        e = rdQ.pop_front();
    endtask

    task automatic test_continuous();
        rdExp_t e;
        doneAt.delete();
        stepCycle(1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
        e = rdQ.pop_front();
        for (int c = 0; c < 2 * int'(NPIX); c++) begin
            stepCycle(1'b0, 1'b0, 1'b1, 8'(expCol + expRow), 5, 3);
            e = rdQ.pop_front();
            nAssert += 3;
            if (oReady !== 1'b1) begin nFail++; $display("FAIL cont_oReady c=%0d got=%b exp=1", c, oReady); end
            if (oWrCol !== CW'(expCol) || oWrRow !== CW'(expRow)) begin
                nFail++; $display("FAIL cont_counters c=%0d got=(%0d,%0d) exp=(%0d,%0d)", c, oWrCol, oWrRow, expCol, expRow);
            end
            if (oDone !== expDone) begin nFail++; $display("FAIL cont_oDone c=%0d got=%b exp=%b", c, oDone, expDone); end
            if (e.check) begin
                nAssert++;
                if (oRdData !== e.data) begin nFail++; $display("FAIL cont_rd c=%0d got=%h exp=%h", c, oRdData, e.data); end
            end
        end
        nAssert += 2;
        if (doneAt.size() != 2) begin
            nFail++; $display("FAIL cont_done_count got=%0d exp=2", doneAt.size());
        end else if (doneAt[1] - doneAt[0] != int'(NPIX)) begin
            nFail++; $display("FAIL cont_done_gap got=%0d exp=%0d", doneAt[1] - doneAt[0], NPIX);
        end
        if (oWrCol !== '0 || oWrRow !== '0) begin nFail++; $display("FAIL cont_wrap got=(%0d,%0d) exp=(0,0)", oWrCol, oWrRow); end
    endtask

    initial begin
        test_reset();
`ifdef CONTINUOUS_FRAME_EN
        test_continuous();
`else
        test_full_frame();
        test_idle_ignored();
        test_read_range();
        test_reset_midframe();
        test_valid_gaps();
        test_same_addr();
`endif
        if (rdQ.size() != 0) begin
            nAssert++; nFail++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", rdQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
